// File: rtl/sdram_arbiter_pkg.sv
// rtl/sdram_arbiter_pkg.sv - shared types and constants for the SDRAM port arbiter
package sdram_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 23;
    localparam int NUM_LANES      = 4;
    localparam int LANE_BITS      = 8;
    localparam logic [1:0] LANE_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_ACK  = 2'd2,
        READ_DATA = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - request/ack/data bundle between arbiter and SDRAM controller
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = 23
) ();
    logic [ADDR_WIDTH-1:0] sdram_addr;
    logic [31:0]           sdram_data;
    logic                  sdram_we;
    logic                  sdram_req;
    logic                  sdram_ack;
    logic                  sdram_valid;
    logic [31:0]           sdram_q;

    modport master (
        output sdram_addr, sdram_data, sdram_we, sdram_req,
        input  sdram_ack, sdram_valid, sdram_q
    );

    modport slave (
        input  sdram_addr, sdram_data, sdram_we, sdram_req,
        output sdram_ack, sdram_valid, sdram_q
    );
endinterface

// File: rtl/sdram_arbiter_download_packer.sv
// rtl/sdram_arbiter_download_packer.sv - packs ioctl bytes into 32-bit words and holds one pending write
module download_packer
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [19:0]           ioctl_addr,
    input  logic [7:0]            ioctl_data,
    input  logic                  pend_clear,
    output logic                  pend_valid,
    output logic [ADDR_WIDTH-1:0] pend_addr,
    output logic [31:0]           pend_data,
    output logic                  overflow
);
    logic [31:0]           acc_q, acc_d;
    logic [NUM_LANES-1:0]  lanes_q, lanes_d;
    logic [17:0]           waddr_q, waddr_d;
    logic                  dl_q, dl_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]           pend_data_q, pend_data_d;
    logic                  overflow_q, overflow_d;

    logic                  word_done;
    logic [31:0]           word_data;
    logic [17:0]           word_waddr;
    logic [1:0]            lane;

    assign lane = ioctl_addr[1:0];

    always_comb begin
        acc_d        = acc_q;
        lanes_d      = lanes_q;
        waddr_d      = waddr_q;
        dl_d         = ioctl_download;
        // a write completing this cycle frees the slot for a word finishing now
        pend_valid_d = pend_valid_q & ~pend_clear;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        overflow_d   = overflow_q;
        word_done    = 1'b0;
        word_data    = acc_q;
        word_waddr   = waddr_q;

        if (ioctl_wr && ioctl_download) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane == 2'(l)) begin
                    word_data[l*LANE_BITS +: LANE_BITS] = ioctl_data;
                end
            end
            word_waddr = ioctl_addr[19:2];
            if (lane == LANE_LAST) begin
                word_done = 1'b1;
            end else begin
                acc_d   = word_data;
                lanes_d = lanes_q | (NUM_LANES'(1) << lane);
                waddr_d = word_waddr;
            end
        end else if (dl_q && !ioctl_download && (|lanes_q)) begin
            word_done = 1'b1;
        end

        if (word_done) begin
            acc_d   = '0;
            lanes_d = '0;
            if (pend_valid_d) begin
                overflow_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_addr_d  = ADDR_WIDTH'({word_waddr, 1'b0});
                pend_data_d  = word_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            lanes_q      <= '0;
            waddr_q      <= '0;
            dl_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            lanes_q      <= lanes_d;
            waddr_q      <= waddr_d;
            dl_q         <= dl_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            overflow_q   <= overflow_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_addr  = pend_addr_q;
    assign pend_data  = pend_data_q;
    assign overflow   = overflow_q;

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one SDRAM port between ROM download writes and round-robin readers
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ioctl_download,
    input  logic                          ioctl_wr,
    input  logic [19:0]                   ioctl_addr,
    input  logic [7:0]                    ioctl_data,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            valid,
    output logic [31:0]                   q,
    output logic                          overflow,
    sdram_arbiter_if.master               sdram
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         gnt_q, gnt_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic                  sdram_req_q, sdram_req_d;
    logic                  sdram_we_q, sdram_we_d;
    logic [ADDR_WIDTH-1:0] sdram_addr_q, sdram_addr_d;
    logic [31:0]           sdram_data_q, sdram_data_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [NUM_REQ-1:0]    valid_q, valid_d;
    logic [31:0]           q_q, q_d;

    logic                  pend_valid;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [31:0]           pend_data;
    logic                  pend_clear;

    logic                  found;
    logic [IW-1:0]         pick;
    logic [IW:0]           idx;

    download_packer #(.ADDR_WIDTH(ADDR_WIDTH)) u_packer (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .pend_clear     (pend_clear),
        .pend_valid     (pend_valid),
        .pend_addr      (pend_addr),
        .pend_data      (pend_data),
        .overflow       (overflow)
    );

    // first requesting port at or after the rotation pointer, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_q} + (IW+1)'(i);
            if (idx >= (IW+1)'(NUM_REQ)) begin
                idx = idx - (IW+1)'(NUM_REQ);
            end
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        sdram_req_d  = sdram_req_q;
        sdram_we_d   = sdram_we_q;
        sdram_addr_d = sdram_addr_q;
        sdram_data_d = sdram_data_q;
        ack_d        = '0;
        valid_d      = '0;
        q_d          = q_q;
        pend_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_valid) begin
                    sdram_req_d  = 1'b1;
                    sdram_we_d   = 1'b1;
                    sdram_addr_d = pend_addr;
                    sdram_data_d = pend_data;
                    state_d      = WRITE;
                end else if (!ioctl_download && found) begin
                    sdram_req_d  = 1'b1;
                    sdram_we_d   = 1'b0;
                    sdram_addr_d = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    gnt_d        = pick;
                    state_d      = READ_ACK;
                end
            end
            WRITE: begin
                if (sdram.sdram_ack) begin
                    sdram_req_d = 1'b0;
                    sdram_we_d  = 1'b0;
                    pend_clear  = 1'b1;
                    state_d     = IDLE;
                end
            end
            READ_ACK: begin
                if (sdram.sdram_ack) begin
                    ack_d[gnt_q] = 1'b1;
                    sdram_req_d  = 1'b0;
                    rr_d         = (gnt_q == IW'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
                    state_d      = READ_DATA;
                end
            end
            READ_DATA: begin
                if (sdram.sdram_valid) begin
                    q_d            = sdram.sdram_q;
                    valid_d[gnt_q] = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            rr_q         <= '0;
            sdram_req_q  <= 1'b0;
            sdram_we_q   <= 1'b0;
            sdram_addr_q <= '0;
            sdram_data_q <= '0;
            ack_q        <= '0;
            valid_q      <= '0;
            q_q          <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            sdram_req_q  <= sdram_req_d;
            sdram_we_q   <= sdram_we_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_data_q <= sdram_data_d;
            ack_q        <= ack_d;
            valid_q      <= valid_d;
            q_q          <= q_d;
        end
    end

    assign ack              = ack_q;
    assign valid            = valid_q;
    assign q                = q_q;
    assign sdram.sdram_req  = sdram_req_q;
    assign sdram.sdram_we   = sdram_we_q;
    assign sdram.sdram_addr = sdram_addr_q;
    assign sdram.sdram_data = sdram_data_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single 32-bit SDRAM controller port between the ROM download path and NUM_REQ read requesters (main CPU, sound CPU, tile/sprite ROM fetchers). During download it packs ioctl bytes into 32-bit words and writes them. Otherwise it round-robins read requests and routes returned data to the granted requester. It sits between the tecmo game core's ROM clients and the sdram controller instance.

Parameters:
NUM_REQ, 4, number of read requester ports (2..8)
ADDR_WIDTH, 23, SDRAM word address width (16-bit word units; one 32-bit access covers addr and addr+1)

Ports:
clk  in  1  system clock (96 MHz)
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  ROM download active
ioctl_wr  in  1  download byte strobe, one cycle
ioctl_addr  in  20  download byte address
ioctl_data  in  8  download byte
req  in  NUM_REQ  per-port read request, level, held until that port's ack
req_addr  in  NUM_REQ*ADDR_WIDTH  per-port word address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH], stable while req high
ack  out  NUM_REQ  per-port one-cycle pulse: request accepted
valid  out  NUM_REQ  per-port one-cycle pulse: q holds that port's data
q  out  32  registered read data, shared
overflow  out  1  sticky: download word lost
sdram_addr  out  ADDR_WIDTH  to controller
sdram_data  out  32  write data
sdram_we  out  1  write enable, qualified by sdram_req
sdram_req  out  1  request, held until sdram_ack
sdram_ack  in  1  controller accepted request, one cycle
sdram_valid  in  1  read data valid, one cycle
sdram_q  in  32  read data

Behaviour:
- Reset (async): all outputs 0, state IDLE, rr pointer 0, accumulator/pending cleared, overflow 0. Reset mid-transaction abandons it; no ack/valid is emitted for it.
- States: IDLE, WRITE, READ_ACK, READ_DATA. One outstanding SDRAM transaction at a time.
- Packing: on ioctl_wr with ioctl_download high, byte stored in accumulator lane ioctl_addr[1:0] (lane 0 = [7:0], little-endian). Byte at lane 3 moves full word to pending register with word address {ioctl_addr[19:2],1'b0} zero-extended; accumulator cleared.
- Falling edge of ioctl_download with any lane written: partial word moved to pending, unwritten lanes 0.
- Pending full and another word completes: new word dropped, overflow set (cleared only by reset).
- Priority: pending write beats all reads. Reads granted only when ioctl_download low and no pending write.
- IDLE, pending valid: sdram_req=1, sdram_we=1, addr/data from pending, next cycle -> WRITE. WRITE on sdram_ack: sdram_req=0 next cycle, pending cleared, -> IDLE.
- IDLE, any req: grant lowest index >= rr pointer (wrapping); sdram_req=1, sdram_we=0, sdram_addr=granted req_addr, next cycle -> READ_ACK. On sdram_ack: ack[g] pulses next cycle, sdram_req drops, rr pointer = g+1 mod NUM_REQ, -> READ_DATA. On sdram_valid: q<=sdram_q and valid[g] pulse same next cycle, -> IDLE.
- Latency, idle arbiter: req->sdram_req 1 cycle; sdram_ack->ack 1 cycle; sdram_valid->valid/q 1 cycle.
- Download rising while READ_ACK/READ_DATA: read completes normally (ack and valid delivered), then write.
- Requester dropping req before ack is a protocol violation; arbiter still completes and pulses ack/valid.
- sdram_valid outside READ_DATA ignored. ack/valid/sdram_we never asserted for two ports in one cycle.

Decomposition:
- Shared package sdram_arbiter_pkg: state enum, ADDR_WIDTH default, lane constants.
- Sub-module download_packer (accumulator, pending register, flush-on-edge, overflow); arbiter FSM and round-robin in top.

Test Plan:
- Download bytes 0x11,0x22,0x33,0x44 at addr 0x00010-0x00013 -> one write, sdram_addr=0x000008, sdram_data=0x44332211, sdram_we=1.
- Download 2 bytes 0xAA,0xBB at 0x00020-21, then download falls -> write addr 0x000010, data 0x0000BBAA.
- req=4'b1111, controller acks after 3 cycles, valid 5 later -> grants in order 0,1,2,3,0; each ack/valid single pulse, q matches sdram_q.
- Hold sdram_ack low while two further words complete -> first pending word written, second dropped, overflow=1 sticky.
- Download rises during READ_DATA of port 2 -> valid[2] pulses with data, then pending write issued; no read grants while ioctl_download=1.
- Assert reset during READ_ACK -> sdram_req=0, ack/valid/q=0 immediately; after release, first grant goes to port 0.
